prince_core: RTL and testbench



---
 rtl/prince_core.sv | 113 +++++++++++
 tb/tb_prince_core.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/prince_core.sv
// Fully unrolled PRINCE block cipher (64-bit block, 128-bit key) with a
// registered output; d selects encrypt (0) or decrypt (1).
module prince_core (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d,
  input  logic [0:63]   inp,
  input  logic [0:127]  key,
  output logic [0:63]   out
);

  localparam logic [63:0] ALPHA = 64'hC0AC29B7C97C50DD;

  localparam logic [63:0] RC [12] = '{
    64'h0000000000000000, 64'h13198A2E03707344, 64'hA4093822299F31D0,
    64'h082EFA98EC4E6C89, 64'h452821E638D01377, 64'hBE5466CF34E90C6C,
    64'h7EF84F78FD955CB1, 64'h85840851F1AC43AA, 64'hC882D32F25323C54,
    64'h64A51195E0E3610D, 64'hD3B5A399CA0C2399, 64'hC0AC29B7C97C50DD
  };

  localparam int SRP [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hB;  4'h1: y = 4'hF;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
      4'h4: y = 4'hA;  4'h5: y = 4'hC;  4'h6: y = 4'h9;  4'h7: y = 4'h1;
      4'h8: y = 4'h6;  4'h9: y = 4'h7;  4'hA: y = 4'h8;  4'hB: y = 4'h0;
      4'hC: y = 4'hE;  4'hD: y = 4'h5;  4'hE: y = 4'hD;  default: y = 4'h4;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hB;  4'h1: y = 4'h7;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
      4'h4: y = 4'hF;  4'h5: y = 4'hD;  4'h6: y = 4'h8;  4'h7: y = 4'h9;
      4'h8: y = 4'hA;  4'h9: y = 4'h6;  4'hA: y = 4'h4;  4'hB: y = 4'h0;
      4'hC: y = 4'h5;  4'hD: y = 4'hE;  4'hE: y = 4'hC;  default: y = 4'h1;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++)
      y[4*i +: 4] = inv ? sbox_inv(x[4*i +: 4]) : sbox(x[4*i +: 4]);
    return y;
  endfunction

  // Bit numbering here is MSB-first (bit j lives at x[63-j]); chunks 1 and 2
  // use M-hat-1, whose block rows are those of M-hat-0 shifted up by one.
  function automatic logic [63:0] mprime(input logic [63:0] x);
    logic [63:0] y;
    logic        acc;
    int          o;
    y = '0;
    for (int q = 0; q < 4; q++) begin
      o = (q == 1 || q == 2) ? 1 : 0;
      for (int r = 0; r < 4; r++) begin
        for (int b = 0; b < 4; b++) begin
          acc = 1'b0;
          for (int c = 0; c < 4; c++)
            if (((r + o + c) % 4) != b)
              acc = acc ^ x[63 - (16*q + 4*c + b)];
          y[63 - (16*q + 4*r + b)] = acc;
        end
      end
    end
    return y;
  endfunction

  function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      if (inv) y[63 - 4*SRP[i] -: 4] = x[63 - 4*i -: 4];
      else     y[63 - 4*i -: 4]      = x[63 - 4*SRP[i] -: 4];
    end
    return y;
  endfunction

  logic [63:0] k0, k1, k0p, ka, kb, kc, st, res, out_q;

  assign k0  = key[0:63];
  assign k1  = key[64:127];
  assign k0p = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};

  // Decryption reuses the encrypt datapath via the alpha-reflection property.
  assign ka = d ? k0p : k0;
  assign kb = d ? k0 : k0p;
  assign kc = d ? (k1 ^ ALPHA) : k1;

  always_comb begin
    st = inp ^ ka ^ kc ^ RC[0];
    for (int i = 1; i <= 5; i++)
      st = shift_rows(mprime(s_layer(st, 1'b0)), 1'b0) ^ RC[i] ^ kc;
    st = s_layer(mprime(s_layer(st, 1'b0)), 1'b1);
    for (int i = 6; i <= 10; i++)
      st = s_layer(mprime(shift_rows(st ^ kc ^ RC[i], 1'b1)), 1'b1);
    res = st ^ kc ^ RC[11] ^ kb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= res;
  end

  assign out = out_q;

endmodule

// File: tb/tb_prince_core.sv
// Scoreboard bench for prince_core: the driver queues the expected result for
// every vector it applies, and an independent monitor checks each cycle.
module tb_prince_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         d = 1'b0;
  logic [0:63]  inp = '0;
  logic [0:127] key = '0;
  logic [0:63]  out;

  logic [63:0] expq [$];
  int          idq [$];
  int          vectors = 0;
  int          miscompares = 0;

  logic [63:0]  tin  [10];
  logic [63:0]  tout [10];
  logic [127:0] tkey [10];
  logic         td   [10];

  prince_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .inp   (inp),
    .key   (key),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic dm, input logic [63:0] din, input logic [127:0] k,
                               input bit push, input logic [63:0] exp, input int id);
    @(negedge clk);
    d   = dm;
    inp = din;
    key = k;
    if (push) begin
      expq.push_back(exp);
      idq.push_back(id);
    end
  endtask

  // Monitor: every vector queued before an edge is checked just after it.
  initial begin
    logic [63:0] e;
    int          id;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e  = expq.pop_front();
        id = idq.pop_front();
        checkOutput($sformatf("vec%0d", id), out, e);
      end
    end
  end

  initial begin
    logic [63:0]  x, c;
    logic [127:0] k;
    int           guard;

    tin  = '{64'h0000000000000000, 64'h818665AA0D02DFDA, 64'h0123456789ABCDEF,
             64'hAE25AD3CA8FA9CCF, 64'hFFFFFFFFFFFFFFFF, 64'h604AE6CA03C20ADA,
             64'h0000000000000000, 64'h9FB51935FC3DF524, 64'h0000000000000000,
             64'h78A54CBE737BB7EF};
    tout = '{64'h818665AA0D02DFDA, 64'h0000000000000000, 64'hAE25AD3CA8FA9CCF,
             64'h0123456789ABCDEF, 64'h604AE6CA03C20ADA, 64'hFFFFFFFFFFFFFFFF,
             64'h9FB51935FC3DF524, 64'h0000000000000000, 64'h78A54CBE737BB7EF,
             64'h0000000000000000};
    tkey = '{128'h0, 128'h0,
             128'h0000000000000000_FEDCBA9876543210, 128'h0000000000000000_FEDCBA9876543210,
             128'h0, 128'h0,
             128'hFFFFFFFFFFFFFFFF_0000000000000000, 128'hFFFFFFFFFFFFFFFF_0000000000000000,
             128'h0000000000000000_FFFFFFFFFFFFFFFF, 128'h0000000000000000_FFFFFFFFFFFFFFFF};
    td   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset with arbitrary inputs present
    rst_n = 1'b0;
    d     = 1'b1;
    inp   = 64'hDEADBEEFCAFEF00D;
    key   = 128'h0123456789ABCDEF_0011223344556677;
    #3;
    checkOutput("reset_async", out, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold", out, 64'h0);

    // Release and run the directed table back-to-back, d toggling each cycle
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++)
      applyStimulus(td[i], tin[i], tkey[i], 1'b1, tout[i], i);
    for (int i = 9; i >= 0; i--)
      applyStimulus(td[i], tin[i], tkey[i], 1'b1, tout[i], 10 + i);

    // Asynchronous reset mid-operation, then first edge after release
    applyStimulus(1'b0, tin[2], tkey[2], 1'b0, 64'h0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_midop", out, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    d     = td[4];
    inp   = tin[4];
    key   = tkey[4];
    expq.push_back(tout[4]);
    idq.push_back(20);

    // Random encrypt-then-decrypt round trips
    for (int r = 0; r < 4; r++) begin
      x = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b0, x, k, 1'b0, 64'h0, 0);
      @(posedge clk);
      #2;
      c = out;
      applyStimulus(1'b1, c, k, 1'b1, x, 100 + r);
    end

    guard = 0;
    while (expq.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    checkOutput("drain", 64'(expq.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
